// File: rtl/bpred_pkg.sv
// Shared definitions for the 2-bit BTB branch predictor: counter states and
// the saturating counter step function.
package bpred_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;
    localparam ctr_t CTR_ALLOC = WT;

    function automatic ctr_t sat2_next(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        nxt = ctr;
        unique case (ctr)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = CTR_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bpred_stat_ctr.sv
// Saturating event counter: counts inc pulses and holds at all-ones.
module bpred_stat_ctr #(
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [STAT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bpred_2bit_btb.sv
// Direct-mapped BTB with a 2-bit saturating counter per entry: combinational
// next-PC lookup, MEM-stage training, mispredict redirect and statistics.
module bpred_2bit_btb
    import bpred_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_next_pc,
    input  logic              update_valid,
    input  logic [31:0]       update_pc,
    input  logic              update_taken,
    input  logic [31:0]       update_target,
    input  logic              update_pred_taken,
    input  logic [31:0]       update_pred_target,
    input  logic              inv_all,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic              valid_q  [ENTRIES];
    ctr_t              ctr_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];

    logic [IDX_W-1:0]  l_idx;
    logic [TAG_W-1:0]  l_tag;
    logic [IDX_W-1:0]  u_idx;
    logic [TAG_W-1:0]  u_tag;
    logic              u_hit;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[31:IDX_W+2];
    assign u_idx = update_pc[IDX_W+1:2];
    assign u_tag = update_pc[31:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Lookup reads registered state only, so a same-cycle update is not visible.
    always_comb begin
        pred_hit     = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        pred_taken   = pred_hit && (ctr_q[l_idx] inside {WT, ST});
        pred_next_pc = pred_taken ? target_q[l_idx] : lookup_pc + 32'd4;
    end

    always_comb begin
        redirect_valid = update_valid &&
                         ((update_pred_taken != update_taken) ||
                          (update_taken && (update_pred_target != update_target)));
        redirect_pc    = update_taken ? update_target : update_pc + 32'd4;
    end

    // inv_all takes priority over any update presented in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                ctr_q[i]    <= CTR_RESET;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (inv_all) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (update_valid) begin
            if (u_hit) begin
                ctr_q[u_idx] <= sat2_next(ctr_q[u_idx], update_taken);
                if (update_taken) begin
                    target_q[u_idx] <= update_target;
                end
            end else if (update_taken) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= update_target;
                ctr_q[u_idx]    <= CTR_ALLOC;
            end
        end
    end

    bpred_stat_ctr #(.STAT_W(STAT_W)) u_stat_branches (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (update_valid),
        .count (stat_branches)
    );

    bpred_stat_ctr #(.STAT_W(STAT_W)) u_stat_mispredicts (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect_valid),
        .count (stat_mispredicts)
    );

endmodule

// File: tb/tb_bpred_2bit_btb.sv
// Self-checking bench for bpred_2bit_btb: directed vectors, a table-level
// reference model checked every cycle, plus literal expectations.
module tb_bpred_2bit_btb;

    localparam int unsigned ENT      = 16;
    localparam int unsigned IDXB     = $clog2(ENT);
    localparam int unsigned STAT_MAX = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] lookup_pc = 32'h40;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_next_pc;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        update_pred_taken = 1'b0;
    logic [31:0] update_pred_target = '0;
    logic        inv_all = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] stat_branches, stat_mispredicts;

    int total = 0;
    int bad = 0;

    bpred_2bit_btb #(.ENTRIES(16), .STAT_W(16)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .lookup_pc          (lookup_pc),
        .pred_hit           (pred_hit),
        .pred_taken         (pred_taken),
        .pred_next_pc       (pred_next_pc),
        .update_valid       (update_valid),
        .update_pc          (update_pc),
        .update_taken       (update_taken),
        .update_target      (update_target),
        .update_pred_taken  (update_pred_taken),
        .update_pred_target (update_pred_target),
        .inv_all            (inv_all),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .stat_branches      (stat_branches),
        .stat_mispredicts   (stat_mispredicts)
    );

    always #5 clk = ~clk;

    // Reference model: table of entries kept as plain integers.
    bit          m_valid [ENT];
    int unsigned m_tag   [ENT];
    int unsigned m_tgt   [ENT];
    int          m_ctr   [ENT];
    int unsigned m_br;
    int unsigned m_mis;

    function automatic bit model_mis();
        return update_valid &&
               ((update_pred_taken != update_taken) ||
                (update_taken && (update_pred_target != update_target)));
    endfunction

    initial begin
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_br = 0; m_mis = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < ENT; i++) begin
                    m_valid[i] <= 0; m_tag[i] <= 0; m_tgt[i] <= 0; m_ctr[i] <= 1;
                end
                m_br <= 0; m_mis <= 0;
            end else begin
                int unsigned ix, tg;
                ix = (update_pc >> 2) % ENT;
                tg = update_pc >> (2 + IDXB);
                if (update_valid && m_br < STAT_MAX) m_br <= m_br + 1;
                if (model_mis() && m_mis < STAT_MAX) m_mis <= m_mis + 1;
                if (inv_all) begin
                    for (int i = 0; i < ENT; i++) m_valid[i] <= 0;
                end else if (update_valid) begin
                    if (m_valid[ix] && m_tag[ix] == tg) begin
                        m_ctr[ix] <= update_taken ? ((m_ctr[ix] == 3) ? 3 : m_ctr[ix] + 1)
                                                  : ((m_ctr[ix] == 0) ? 0 : m_ctr[ix] - 1);
                        if (update_taken) m_tgt[ix] <= update_target;
                    end else if (update_taken) begin
                        m_valid[ix] <= 1; m_tag[ix] <= tg;
                        m_tgt[ix] <= update_target; m_ctr[ix] <= 2;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial forever begin
        int unsigned ix, tg;
        bit hit, tk;
        @(negedge clk);
        ix  = (lookup_pc >> 2) % ENT;
        tg  = lookup_pc >> (2 + IDXB);
        hit = m_valid[ix] && (m_tag[ix] == tg);
        tk  = hit && (m_ctr[ix] >= 2);
        chk("m_hit",   {31'd0, pred_hit},   {31'd0, hit});
        chk("m_taken", {31'd0, pred_taken}, {31'd0, tk});
        chk("m_npc",   pred_next_pc, tk ? m_tgt[ix] : lookup_pc + 32'd4);
        chk("m_redir", {31'd0, redirect_valid}, {31'd0, model_mis()});
        chk("m_rpc",   redirect_pc, update_taken ? update_target : update_pc + 32'd4);
        chk("m_br",    {16'd0, stat_branches},    m_br);
        chk("m_mis",   {16'd0, stat_mispredicts}, m_mis);
    end

    task automatic cyc(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic upt,
                       input logic [31:0] uptgt, input logic inv);
        @(posedge clk);
        #1;
        lookup_pc = lpc; update_valid = uv; update_pc = upc; update_taken = ut;
        update_target = utgt; update_pred_taken = upt; update_pred_target = uptgt;
        inv_all = inv;
        #1;
    endtask

    task automatic idle(input logic [31:0] lpc);
        cyc(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_hit", {31'd0, pred_hit}, 32'd0);
        chk("rst_npc", pred_next_pc, 32'h44);
        chk("rst_br",  {16'd0, stat_branches}, 32'd0);
        #9 rst_n = 1'b1;

        idle(32'h40);
        chk("A_hit", {31'd0, pred_hit}, 32'd0);
        chk("A_taken", {31'd0, pred_taken}, 32'd0);
        chk("A_npc", pred_next_pc, 32'h44);
        chk("A_mis", {16'd0, stat_mispredicts}, 32'd0);

        // Allocation, with a same-cycle lookup that must not see it.
        cyc(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0);
        chk("B_redir", {31'd0, redirect_valid}, 32'd1);
        chk("B_rpc", redirect_pc, 32'h100);
        chk("B_hit", {31'd0, pred_hit}, 32'd0);
        idle(32'h40);
        chk("C_hit", {31'd0, pred_hit}, 32'd1);
        chk("C_taken", {31'd0, pred_taken}, 32'd1);
        chk("C_npc", pred_next_pc, 32'h100);
        chk("C_mis", {16'd0, stat_mispredicts}, 32'd1);
        chk("C_br", {16'd0, stat_branches}, 32'd1);

        // Hysteresis: WT -> WNT -> WT -> ST -> WT.
        cyc(32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100, 0);
        chk("D_rpc", redirect_pc, 32'h44);
        idle(32'h40);
        chk("E_hit", {31'd0, pred_hit}, 32'd1);
        chk("E_npc", pred_next_pc, 32'h44);
        cyc(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0);
        cyc(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0);
        cyc(32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100, 0);
        chk("H_redir", {31'd0, redirect_valid}, 32'd1);
        chk("H_rpc", redirect_pc, 32'h44);
        idle(32'h40);
        chk("I_npc", pred_next_pc, 32'h100);
        cyc(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 0);
        chk("J_redir", {31'd0, redirect_valid}, 32'd0);
        cyc(32'h40, 1, 32'h40, 1, 32'h104, 1, 32'h100, 0);
        chk("K_redir", {31'd0, redirect_valid}, 32'd1);
        chk("K_rpc", redirect_pc, 32'h104);
        idle(32'h40);
        chk("L_npc", pred_next_pc, 32'h104);

        // Aliasing: 0x80 shares index 0 with 0x40.
        idle(32'h80);
        chk("M_hit", {31'd0, pred_hit}, 32'd0);
        chk("M_npc", pred_next_pc, 32'h84);
        cyc(32'h80, 1, 32'h80, 1, 32'h200, 0, 32'h84, 0);
        idle(32'h80);
        chk("O_hit", {31'd0, pred_hit}, 32'd1);
        chk("O_npc", pred_next_pc, 32'h200);
        idle(32'h40);
        chk("P_hit", {31'd0, pred_hit}, 32'd0);
        chk("P_npc", pred_next_pc, 32'h44);

        // inv_all beats a same-cycle allocating update.
        cyc(32'h80, 1, 32'h300, 1, 32'h500, 0, 32'h304, 1);
        chk("Q_hit", {31'd0, pred_hit}, 32'd1);
        idle(32'h80);
        chk("R_hit", {31'd0, pred_hit}, 32'd0);
        chk("R_br", {16'd0, stat_branches}, 32'd9);
        chk("R_mis", {16'd0, stat_mispredicts}, 32'd8);
        idle(32'h300);
        chk("S_hit", {31'd0, pred_hit}, 32'd0);
        chk("S_npc", pred_next_pc, 32'h304);

        // 32-bit wrap of the sequential PC.
        cyc(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h0, 0);
        chk("T_npc", pred_next_pc, 32'h0);
        chk("T_rpc", redirect_pc, 32'h0);
        chk("T_redir", {31'd0, redirect_valid}, 32'd1);

        // Saturation of both statistics.
        for (int i = 0; i < 65537; i++)
            cyc(32'h1000, 1, 32'h1000, 1, 32'h2000, 0, 32'h1004, 0);
        idle(32'h1000);
        chk("U_br", {16'd0, stat_branches}, 32'hFFFF);
        chk("U_mis", {16'd0, stat_mispredicts}, 32'hFFFF);
        chk("U_hit", {31'd0, pred_hit}, 32'd1);
        for (int i = 0; i < 3; i++)
            cyc(32'h1000, 1, 32'h1000, 1, 32'h2000, 0, 32'h1004, 0);
        chk("V_br", {16'd0, stat_branches}, 32'hFFFF);

        // Asynchronous reset mid-update, checked before the next clock edge.
        #1;
        rst_n = 1'b0;
        update_valid = 1'b0;
        #1;
        chk("W_br", {16'd0, stat_branches}, 32'd0);
        chk("W_mis", {16'd0, stat_mispredicts}, 32'd0);
        chk("W_hit", {31'd0, pred_hit}, 32'd0);
        chk("W_npc", pred_next_pc, 32'h1004);
        #13 rst_n = 1'b1;
        idle(32'h1000);
        chk("X_hit", {31'd0, pred_hit}, 32'd0);
        chk("X_br", {16'd0, stat_branches}, 32'd0);
        idle(32'h1000);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
